multiplier_int8: RTL and testbench
==================================

# multiplier_int8

Signed 8-bit × 8-bit multiplier with a registered 8-bit two's-complement result and an overflow flag. It is the element-wise multiply primitive of the matrix coprocessor datapath. Each cycle it accepts one operand pair and produces the truncated or saturated product one clock later. It also flags any product that does not fit in 8 bits.

## Interface

Parameters:
- None. Operand and result widths are fixed at 8 bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all outputs immediately.
- a  input  8  signed multiplicand, two's complement.
- b  input  8  signed multiplier, two's complement.
- prod  output  8  signed product, registered; truncated or saturated per Configuration.
- ovf  output  1  registered; 1 when the exact product lies outside [-128, 127].

## Operation

- Form the exact 16-bit signed product P = a × b, range [-16256, 16384].
- Build P as a Baugh-Wooley array of 8 partial products summed by an adder tree.
  - No behavioural `*` operator.
  - Sign-correction constants are applied per Baugh-Wooley.
- Overflow rule: ovf_next = 1 unless P[15:7] is all-zeros or all-ones.
- Result rule:
  - Default: prod_next = P[7:0], a two's-complement wrap.
  - With saturation compiled in: see Configuration.
- Boundary cases, all required:
  - -128 × -1 = 128: ovf = 1, prod = 0x80 (wrap).
  - -128 × -128 = 16384: ovf = 1, prod = 0x00 (wrap).
  - -64 × 2 = -128 and 64 × -2 = -128: ovf = 0, prod = 0x80.
  - 0 × anything: prod = 0, ovf = 0.
- No handshake. A new operand pair is accepted every cycle, with full throughput.

## Timing

- Latency is 1 cycle: a and b sampled at rising edge N appear on prod/ovf after edge N.
- prod and ovf are driven directly from flops. There is no combinational path from inputs to outputs.
- Reset value: prod = 8'h00, ovf = 1'b0.
- Reset applies asynchronously on rst rising and holds while rst = 1.
- First capture occurs on the first rising clk edge after rst deasserts.
- Reset mid-operation: the in-flight result is discarded. Outputs read 0 until the first post-reset edge.
- The multiply array must close timing in a single clock period. Pipeline registers inside the array are not permitted, because they would change the latency.

## Configuration

- Macro: MULTIPLIER_SATURATE_EN.
- Defined: when ovf_next = 1, prod_next saturates.
  - P > 127 gives 8'h7F (127).
  - P < -128 gives 8'h80 (-128).
  - ovf behaviour is unchanged.
- Undefined (default): prod_next = P[7:0] always, with wrap-around.
- The macro selects logic only. Ports and latency are identical in both builds.

## Test plan

- Reset: assert rst with a = 5, b = 5.
  - prod = 0 and ovf = 0 immediately, before any clk edge.
  - After release, the next edge gives prod = 25.
- In-range signed products, one result per cycle:
  - -15 × 2 → prod = 0xE2 (-30), ovf = 0.
  - 4 × 4 → 0x10 (16), ovf = 0.
  - 40 × -3 → 0x88 (-120), ovf = 0.
  - -23 × 2 → 0xD2 (-46), ovf = 0.
  - -5 × -3 → 0x0F (15), ovf = 0.
- Exact lower limit:
  - -64 × 2 → prod = 0x80 (-128), ovf = 0.
  - 64 × -2 → prod = 0x80 (-128), ovf = 0.
- Overflow, default build:
  - -128 × -1 → ovf = 1, prod = 0x80.
  - 100 × 2 → ovf = 1, prod = 0xC8.
  - 40 × 40 → ovf = 1, prod = 0x40.
  - -128 × -2 → ovf = 1, prod = 0x00.
- Overflow, MULTIPLIER_SATURATE_EN build:
  - 100 × 2 → 0x7F.
  - -128 × -1 → 0x7F.
  - 40 × -4 → 0x80.
  - ovf = 1 for all three.
- Back-to-back vectors:
  - Change operands every cycle.
  - Verify each result appears exactly one edge later.
  - Assert rst mid-stream and verify the outputs clear immediately.

Source files
------------

// File: rtl/multiplier_int8.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_int8
// Purpose  : Signed 8x8 multiplier for the matrix coprocessor datapath.
//            The exact 16-bit product comes from a Baugh-Wooley array of
//            eight partial-product rows summed by a three-level adder tree.
//            The 8-bit result and an overflow flag are registered, which
//            gives a latency of one cycle and accepts one pair per cycle.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset, clears prod/ovf
//            a    - signed multiplicand [7:0]
//            b    - signed multiplier   [7:0]
//            prod - registered signed product [7:0] (wrap or saturate)
//            ovf  - registered, 1 when the exact product is outside [-128,127]
// Config   : MULTIPLIER_SATURATE_EN - when defined, an overflowing product
//            saturates to 8'h7F / 8'h80 instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_int8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] prod,
  output logic       ovf
);

  // Baugh-Wooley correction: the inverted sign-cross terms leave a bias
  // that is cancelled by adding 2^8 + 2^15 (modulo 2^16).
  localparam logic [15:0] C_BW_CORR = 16'h8100;

  logic [15:0] w_row [8];

  // Row i holds a * b[i], shifted left by i. The cross terms involving
  // exactly one sign bit are inverted; the sign*sign term stays positive.
  for (genvar i = 0; i < 8; i++) begin : g_row
    logic [7:0] w_bits;
    for (genvar j = 0; j < 8; j++) begin : g_col
      if ((i == 7) != (j == 7)) begin : g_inv
        assign w_bits[j] = ~(a[j] & b[i]);
      end else begin : g_pos
        assign w_bits[j] = a[j] & b[i];
      end
    end
    assign w_row[i] = {8'h00, w_bits} << i;
  end

  // Balanced adder tree; all sums are modulo 2^16.
  logic [15:0] w_sum_l1 [4];
  logic [15:0] w_sum_l2 [2];
  logic [15:0] w_p;

  for (genvar k = 0; k < 4; k++) begin : g_tree_l1
    assign w_sum_l1[k] = w_row[2*k] + w_row[2*k+1];
  end

  for (genvar k = 0; k < 2; k++) begin : g_tree_l2
    assign w_sum_l2[k] = w_sum_l1[2*k] + w_sum_l1[2*k+1];
  end

  assign w_p = w_sum_l2[0] + w_sum_l2[1] + C_BW_CORR;

  // The product fits in 8 bits exactly when bits 15..7 are a pure sign
  // extension (all zeros or all ones).
  logic       w_ovf;
  logic [7:0] w_prod;

  assign w_ovf = ~((&w_p[15:7]) | ~(|w_p[15:7]));

`ifdef MULTIPLIER_SATURATE_EN
  // The sign of the exact product selects the saturation rail.
  assign w_prod = w_ovf ? (w_p[15] ? 8'h80 : 8'h7F) : w_p[7:0];
`else
  assign w_prod = w_p[7:0];
`endif

  logic [7:0] r_prod;
  logic       r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod <= 8'h00;
      r_ovf  <= 1'b0;
    end else begin
      r_prod <= w_prod;
      r_ovf  <= w_ovf;
    end
  end

  assign prod = r_prod;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_int8.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_int8
// Purpose  : Self-checking bench for multiplier_int8. Each driven operand
//            pair pushes its expected {prod, ovf} into a scoreboard queue;
//            the entry is popped and compared one edge later. Directed
//            vectors use hand-derived constants; a random back-to-back run
//            uses a behavioural reference model.
// Config   : MULTIPLIER_SATURATE_EN - selects saturated expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_int8;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] prod;
  logic       ovf;

  multiplier_int8 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .prod (prod),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] sbq [$];
  logic [8:0] last_exp;
  bit         have_last = 1'b0;

`ifdef MULTIPLIER_SATURATE_EN
  localparam logic [7:0] E_100X2    = 8'h7F;
  localparam logic [7:0] E_40X40    = 8'h7F;
  localparam logic [7:0] E_M128XM2  = 8'h7F;
  localparam logic [7:0] E_M128XM1  = 8'h7F;
  localparam logic [7:0] E_40XM4    = 8'h80;
  localparam logic [7:0] E_127X127  = 8'h7F;
  localparam logic [7:0] E_M128X127 = 8'h80;
`else
  localparam logic [7:0] E_100X2    = 8'hC8;
  localparam logic [7:0] E_40X40    = 8'h40;
  localparam logic [7:0] E_M128XM2  = 8'h00;
  localparam logic [7:0] E_M128XM1  = 8'h80;
  localparam logic [7:0] E_40XM4    = 8'h60;
  localparam logic [7:0] E_127X127  = 8'h01;
  localparam logic [7:0] E_M128X127 = 8'h80;
`endif

  // Behavioural reference for the random stream.
  function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb);
    int         p;
    logic       o;
    logic [7:0] r;
    logic [15:0] pv;
    p  = int'($signed(ma)) * int'($signed(mb));
    pv = p[15:0];
    o  = (p > 127) || (p < -128);
    r  = pv[7:0];
`ifdef MULTIPLIER_SATURATE_EN
    if (p > 127)  r = 8'h7F;
    if (p < -128) r = 8'h80;
`endif
    return {r, o};
  endfunction

  task automatic check(input string tag, input logic [7:0] gp, input logic go,
                       input logic [7:0] ep, input logic eo);
    n_vec++;
    assert ({gp, go} === {ep, eo})
    else begin
      n_err++;
      $error("FAIL %s: got prod=%h ovf=%b, expected prod=%h ovf=%b", tag, gp, go, ep, eo);
    end
  endtask

  // Called one time unit after a rising edge. Drives a pair, verifies the
  // outputs do not follow the new inputs before the edge, then checks the
  // scoreboard entry one edge later.
  task automatic step(input string tag, input logic [7:0] va, input logic [7:0] vb,
                      input logic [8:0] e);
    logic [8:0] got_exp;
    a = va;
    b = vb;
    sbq.push_back(e);
    #1;
    if (have_last) check({tag, "_hold"}, prod, ovf, last_exp[8:1], last_exp[0]);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_sb: scoreboard empty, got prod=%h, expected an entry", tag, prod);
    end else begin
      got_exp = sbq.pop_front();
      check(tag, prod, ovf, got_exp[8:1], got_exp[0]);
      last_exp  = got_exp;
      have_last = 1'b1;
    end
  endtask

  // Called one time unit after a rising edge; reset is asserted between
  // edges to show it acts asynchronously.
  task automatic mid_reset(input string tag);
    a = 8'd4;
    b = 8'd4;
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_async"}, prod, ovf, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_held"}, prod, ovf, 8'h00, 1'b0);
    rst = 1'b0;
    sbq.delete();
    have_last = 1'b0;
    #1;
    check({tag, "_prefirst"}, prod, ovf, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_first"}, prod, ovf, 8'h10, 1'b0);
    last_exp  = {8'h10, 1'b0};
    have_last = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;

    rst = 1'b0;
    a   = 8'd5;
    b   = 8'd5;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", prod, ovf, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", prod, ovf, 8'h00, 1'b0);
    rst = 1'b0;
    step("rst_release", 8'd5, 8'd5, {8'd25, 1'b0});

    // In-range products, one per cycle.
    step("m15x2",  8'hF1, 8'h02, {8'hE2, 1'b0});
    step("4x4",    8'h04, 8'h04, {8'h10, 1'b0});
    step("40xm3",  8'h28, 8'hFD, {8'h88, 1'b0});
    step("m23x2",  8'hE9, 8'h02, {8'hD2, 1'b0});
    step("m5xm3",  8'hFB, 8'hFD, {8'h0F, 1'b0});

    // Exact lower limit.
    step("m64x2",  8'hC0, 8'h02, {8'h80, 1'b0});
    step("64xm2",  8'h40, 8'hFE, {8'h80, 1'b0});

    // Zero operand.
    step("0xm128", 8'h00, 8'h80, {8'h00, 1'b0});
    step("127x0",  8'h7F, 8'h00, {8'h00, 1'b0});

    // Overflow.
    step("m128xm1",  8'h80, 8'hFF, {E_M128XM1, 1'b1});
    step("100x2",    8'h64, 8'h02, {E_100X2, 1'b1});
    step("40x40",    8'h28, 8'h28, {E_40X40, 1'b1});
    step("m128xm2",  8'h80, 8'hFE, {E_M128XM2, 1'b1});
    step("40xm4",    8'h28, 8'hFC, {E_40XM4, 1'b1});
    step("127x127",  8'h7F, 8'h7F, {E_127X127, 1'b1});
    step("m128x127", 8'h80, 8'h7F, {E_M128X127, 1'b1});
    step("m128xm128",8'h80, 8'h80, {8'h00 | E_M128XM2, 1'b1});
    step("m1xm1",    8'hFF, 8'hFF, {8'h01, 1'b0});

    // Reset while an overflowing result is on the outputs.
    step("pre_rst",  8'h80, 8'hFF, {E_M128XM1, 1'b1});
    mid_reset("rst_mid");

    // Random back-to-back stream against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      step("rand", ra, rb, model(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
